// File: rtl/xm_mem_responder.sv
// Memory-side responder for the XM CPU bus: word-organised RAM served after WAIT wait states.
// Optional misaligned-word fault reporting is enabled by defining XM_MEM_ALIGN_CHECK_EN.
module xm_mem_responder #(
    parameter int WORD    = 16,
    parameter int DEPTH_W = 9,
    parameter int WAIT    = 2
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] adr_i,
    input  logic [WORD-1:0] data_i,
    output logic [WORD-1:0] data_o,
    output logic            memBusy_o,
    output logic            memWr_o
`ifdef XM_MEM_ALIGN_CHECK_EN
    ,
    output logic            memFault_o
`endif
);

    typedef enum logic {IDLE, BUSY} stateT;

    stateT              state;
    logic [3:0]         cnt;
    logic [DEPTH_W:0]   adrQ;
    logic [WORD-1:0]    dataQ;
    logic               rwQ;
    logic               byteQ;

    logic [WORD-1:0]    ram [2**DEPTH_W];

    logic [DEPTH_W-1:0] idx;
    logic               lane;
    logic               done;
    logic               misalign;
    logic [WORD-1:0]    rdWord;
    logic [7:0]         rdByte;
    logic               unusedAdrBits;

    // Only the bits that select a byte inside the RAM are kept; higher bits alias.
    assign unusedAdrBits = ^adr_i[WORD-1:DEPTH_W+1];

    assign idx    = adrQ[DEPTH_W:1];
    assign lane   = adrQ[0];
    assign done   = (state == BUSY) && (cnt == 4'd0);
    assign rdWord = ram[idx];
    assign rdByte = lane ? rdWord[15:8] : rdWord[7:0];

`ifdef XM_MEM_ALIGN_CHECK_EN
    assign misalign = !byteQ && adrQ[0];
`else
    assign misalign = 1'b0;
`endif

    // NOTE: the RAM has no reset; contents survive arst_i and only the access in flight is lost.
    always_ff @(posedge clk_i) begin
        if (done && rwQ && !misalign) begin
            if (!byteQ)    ram[idx]       <= dataQ;
            else if (lane) ram[idx][15:8] <= dataQ[7:0];
            else           ram[idx][7:0]  <= dataQ[7:0];
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            adrQ      <= '0;
            dataQ     <= '0;
            rwQ       <= 1'b0;
            byteQ     <= 1'b0;
            data_o    <= '0;
            memBusy_o <= 1'b0;
            memWr_o   <= 1'b0;
`ifdef XM_MEM_ALIGN_CHECK_EN
            memFault_o <= 1'b0;
`endif
        end else begin
            memWr_o <= 1'b0;
`ifdef XM_MEM_ALIGN_CHECK_EN
            memFault_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (memEn_i) begin
                        adrQ      <= adr_i[DEPTH_W:0];
                        dataQ     <= data_i;
                        rwQ       <= memRW_i;
                        byteQ     <= byteOp_i;
                        cnt       <= 4'(WAIT);
                        memBusy_o <= 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        memBusy_o <= 1'b0;
                        state     <= IDLE;
                        if (misalign) begin
`ifdef XM_MEM_ALIGN_CHECK_EN
                            memFault_o <= 1'b1;
`endif
                        end else if (!rwQ) begin
                            memWr_o <= 1'b1;
                            data_o  <= byteQ ? WORD'(rdByte) : rdWord;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xm_mem_responder.sv
// Self-checking bench: two responders (WAIT=2 and WAIT=0) compared every cycle
// against a transaction-level model, plus directed literal checks.
module tb_xm_mem_responder;

    logic        clk = 1'b0;
    logic        arst;
    logic        en   [2];
    logic        rw   [2];
    logic        bo   [2];
    logic [15:0] adr  [2];
    logic [15:0] din  [2];
    logic [15:0] dout [2];
    logic        busy [2];
    logic        wr   [2];
`ifdef XM_MEM_ALIGN_CHECK_EN
    logic        fault [2];
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    xm_mem_responder #(.WORD(16), .DEPTH_W(9), .WAIT(2)) u0 (
        .clk_i(clk), .arst_i(arst), .memEn_i(en[0]), .memRW_i(rw[0]), .byteOp_i(bo[0]),
        .adr_i(adr[0]), .data_i(din[0]), .data_o(dout[0]), .memBusy_o(busy[0]), .memWr_o(wr[0])
`ifdef XM_MEM_ALIGN_CHECK_EN
        , .memFault_o(fault[0])
`endif
    );

    xm_mem_responder #(.WORD(16), .DEPTH_W(9), .WAIT(0)) u1 (
        .clk_i(clk), .arst_i(arst), .memEn_i(en[1]), .memRW_i(rw[1]), .byteOp_i(bo[1]),
        .adr_i(adr[1]), .data_i(din[1]), .data_o(dout[1]), .memBusy_o(busy[1]), .memWr_o(wr[1])
`ifdef XM_MEM_ALIGN_CHECK_EN
        , .memFault_o(fault[1])
`endif
    );

    // Transaction-level model: an access accepted on edge N completes on edge N+W+1.
    int          mW [2] = '{2, 0};
    logic [15:0] mMem [2][512];
    bit          mPend [2];
    int          mDone [2];
    logic        mRw [2], mBo [2];
    logic [15:0] mAdr [2], mDin [2];
    logic        eWr [2], eFault [2];
    logic [15:0] eData [2];
    int          cyc = 0;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mPend[i] = 0; eWr[i] = 0; eFault[i] = 0; eData[i] = 16'h0000;
        end
    endtask

    task automatic modelComplete(input int i);
        int   w;
        logic hi;
        w  = int'(mAdr[i][9:1]);
        hi = mAdr[i][0];
        if (ALIGN && !mBo[i] && hi) begin
            eFault[i] = 1'b1;
        end else if (mRw[i]) begin
            if (!mBo[i])  mMem[i][w] = mDin[i];
            else if (hi)  mMem[i][w][15:8] = mDin[i][7:0];
            else          mMem[i][w][7:0]  = mDin[i][7:0];
        end else begin
            eWr[i] = 1'b1;
            if (!mBo[i])  eData[i] = mMem[i][w];
            else if (hi)  eData[i] = {8'h00, mMem[i][w][15:8]};
            else          eData[i] = {8'h00, mMem[i][w][7:0]};
        end
    endtask

    task automatic modelStep();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            eWr[i] = 1'b0; eFault[i] = 1'b0;
            if (mPend[i] && cyc == mDone[i]) begin
                mPend[i] = 0;
                modelComplete(i);
            end else if (!mPend[i] && en[i]) begin
                mPend[i] = 1;
                mDone[i] = cyc + mW[i] + 1;
                mRw[i] = rw[i]; mBo[i] = bo[i]; mAdr[i] = adr[i]; mDin[i] = din[i];
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge arst);
        if (arst) modelReset();
        else      modelStep();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    initial forever begin
        @(negedge clk);
        if (!arst) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy%0d", i), 32'(busy[i]), 32'(mPend[i]));
                check($sformatf("memWr%0d", i), 32'(wr[i]), 32'(eWr[i]));
                check($sformatf("data%0d", i), 32'(dout[i]), 32'(eData[i]));
`ifdef XM_MEM_ALIGN_CHECK_EN
                check($sformatf("fault%0d", i), 32'(fault[i]), 32'(eFault[i]));
`endif
            end
        end
    end

    // One request: returns busy-cycle count and edges from accept to memWr_o (-1 if none).
    task automatic doAccess(input int i, input logic w, input logic b, input logic [15:0] a,
                            input logic [15:0] d, output int busyCyc, output int wrLat);
        bit finished = 0;
        @(negedge clk);
        en[i] = 1'b1; rw[i] = w; bo[i] = b; adr[i] = a; din[i] = d;
        @(posedge clk);
        busyCyc = 0;
        wrLat   = -1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k == 0) en[i] = 1'b0;
            if (busy[i]) busyCyc++;
            if (wr[i] && wrLat < 0) wrLat = k;
            if (!busy[i]) begin
                finished = 1;
                break;
            end
        end
        if (!finished) check("accessTimeout", 32'(busy[i]), 32'd0);
    endtask

    initial begin
        int bc, lat, pulses;
        arst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; rw[i] = 0; bo[i] = 0; adr[i] = 16'h0; din[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        arst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idleBusy", 32'(busy[0]), 32'd0);
            check("idleWr", 32'(wr[0]), 32'd0);
            check("idleData", 32'(dout[0]), 32'h0000);
        end

        // Prefill words 0..31 of both RAMs so every read in the window is defined.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 32; w++)
                doAccess(i, 1'b1, 1'b0, 16'(w * 2), 16'h1000 + 16'(w) * 16'h0101, bc, lat);

        doAccess(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, bc, lat);
        check("wrBusyCycles", bc, 3);
        check("wrNoPulse", lat, -1);
        doAccess(0, 1'b0, 1'b0, 16'h0010, 16'h0000, bc, lat);
        check("rdBusyCycles", bc, 3);
        check("rdLatency", lat, 3);
        check("rdBeef", 32'(dout[0]), 32'hBEEF);
        check("modelBeef", 32'(eData[0]), 32'hBEEF);

        doAccess(0, 1'b1, 1'b1, 16'h0011, 16'h775A, bc, lat);
        doAccess(0, 1'b0, 1'b1, 16'h0011, 16'h0000, bc, lat);
        check("byteRdHi", 32'(dout[0]), 32'h005A);
        doAccess(0, 1'b0, 1'b0, 16'h0010, 16'h0000, bc, lat);
        check("wordAfterByte", 32'(dout[0]), 32'h5AEF);
        check("modelMerge", 32'(eData[0]), 32'h5AEF);
        doAccess(0, 1'b0, 1'b1, 16'h0010, 16'h0000, bc, lat);
        check("byteRdLo", 32'(dout[0]), 32'h00EF);

        // Reset during the second busy cycle of a write drops it.
        @(negedge clk);
        en[0] = 1'b1; rw[0] = 1'b1; bo[0] = 1'b0; adr[0] = 16'h0020; din[0] = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        @(posedge clk);
        #2 arst = 1'b1;
        #2 arst = 1'b0;
        @(negedge clk);
        check("rstBusy", 32'(busy[0]), 32'd0);
        check("rstWr", 32'(wr[0]), 32'd0);
        check("rstData", 32'(dout[0]), 32'h0000);
        repeat (2) @(negedge clk);
        doAccess(0, 1'b0, 1'b0, 16'h0020, 16'h0000, bc, lat);
        check("writeDropped", 32'(dout[0]), 32'h2010);

        // Aliased upper address bits select the same word.
        doAccess(0, 1'b0, 1'b0, 16'hFC10, 16'h0000, bc, lat);
        check("aliasRead", 32'(dout[0]), 32'h5AEF);

        doAccess(0, 1'b1, 1'b0, 16'h0021, 16'hA5C3, bc, lat);
        check("oddWrBusy", bc, 3);
`ifdef XM_MEM_ALIGN_CHECK_EN
        check("alignFault", 32'(fault[0]), 32'd1);
`endif
        doAccess(0, 1'b0, 1'b0, 16'h0020, 16'h0000, bc, lat);
        check("oddWordWrite", 32'(dout[0]), ALIGN ? 32'h2010 : 32'hA5C3);

        // WAIT=0 responder with memEn held high for 10 edges: one completion every 2 cycles.
        doAccess(1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, bc, lat);
        @(negedge clk);
        en[1] = 1'b1; rw[1] = 1'b0; bo[1] = 1'b0; adr[1] = 16'h0010;
        pulses = 0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 10) en[1] = 1'b0;
            if (wr[1]) pulses++;
        end
        check("b2bPulses", pulses, 5);
        check("b2bData", 32'(dout[1]), 32'hBEEF);

        // Randomized traffic on both responders.
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                en[i]  = ($urandom_range(0, 2) != 0);
                rw[i]  = 1'($urandom_range(0, 1));
                bo[i]  = 1'($urandom_range(0, 1));
                adr[i] = 16'($urandom_range(0, 63)) | (16'($urandom) & 16'hFC00);
                din[i] = 16'($urandom);
            end
        end
        @(negedge clk);
        en[0] = 1'b0; en[1] = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/xm_mem_responder.md
Name: xm_mem_responder

Overview:
- Memory-side responder for the multi-cycle XM CPU's memory bus.
- Accepts the request strobes the control plane issues (enable, read/write, byte-op) plus the datapath address and store data.
- Serves each request from an internal word-organised RAM after a fixed number of wait states.
- Drives busy back to the controller, and a read-data-valid strobe that loads the CPU's memory data register.

Parameters:
- WORD, 16, data/address width in bits.
- DEPTH_W, 9, log2 of RAM depth in words (default 512 words = 1 KiB).
- WAIT, 2, wait states per access (0..15); an access occupies WAIT+1 busy cycles.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- arst_i  in  1  asynchronous, active-high reset.
- memEn_i  in  1  request strobe from controller.
- memRW_i  in  1  1 = write, 0 = read.
- byteOp_i  in  1  1 = byte access, 0 = word access.
- adr_i  in  WORD  byte address.
- data_i  in  WORD  store data; byte writes use data_i[7:0].
- data_o  out  WORD  read data; byte reads zero-extended.
- memBusy_o  out  1  access in progress.
- memWr_o  out  1  one-cycle strobe: data_o valid, CPU loads MDR.

Behaviour:
- Reset: asynchronous on arst_i high.
  - Resets state to IDLE, memBusy_o=0, memWr_o=0, data_o=0, wait counter=0, latched request=0.
  - RAM contents are not reset.
- Organisation:
  - Word index = adr[DEPTH_W:1]; upper address bits are ignored, so addresses alias modulo 2^(DEPTH_W+1) bytes.
  - Little-endian: adr[0]=0 selects bits [7:0], adr[0]=1 selects bits [15:8].
- FSM states: IDLE, BUSY.
- IDLE:
  - If memEn_i=1 at an edge, latch adr_i, data_i, memRW_i and byteOp_i.
  - Load cnt=WAIT, set memBusy_o=1, go to BUSY.
  - Otherwise remain in IDLE; memWr_o=0.
- BUSY:
  - Inputs are ignored; the latched copy is used.
  - cnt!=0: cnt decrements; memBusy_o stays 1.
  - cnt==0: perform the access, memBusy_o=0, go to IDLE.
- Latency: request accepted at edge N completes at edge N+WAIT+1. memBusy_o is high for exactly WAIT+1 cycles.
- Word read: data_o <= RAM[idx]; memWr_o=1 for one cycle.
- Byte read: data_o <= {8'h00, selected byte}; memWr_o=1 for one cycle.
- Word write: RAM[idx] <= data; memWr_o stays 0; data_o unchanged.
- Byte write: only the selected lane <= data[7:0]; the other lane is preserved.
- Word access with adr[0]=1 (without the optional feature): adr[0] is ignored and the access is treated as aligned.
- Back-to-back requests:
  - If memEn_i is still high in the IDLE cycle after completion, a new request is accepted at the next edge.
  - Minimum spacing is WAIT+2 cycles per access.
  - The controller deasserts memEn_i on seeing memWr_o / busy fall.
- Same-address read after write: returns the newly written value; the write commits before any later access starts.
- Reset mid-access: the access is aborted.
  - A pending write is dropped and the RAM is unchanged.
  - No memWr_o pulse is produced.
- memEn_i asserted while memBusy_o=1: ignored, no queuing.

Optional Feature:
- Macro: XM_MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output port memFault_o (1 bit, reset 0).
  - A word access with latched adr[0]=1 still takes WAIT+1 busy cycles.
  - At completion: no RAM write, data_o unchanged, memWr_o=0, memFault_o=1 for one cycle.
- Undefined: no memFault_o port; adr[0] is ignored for word accesses.

Test Plan:
- Reset then idle, WAIT=2 → memBusy_o=0, memWr_o=0, data_o=16'h0000; no busy assertion while memEn_i=0.
- Word write 16'hBEEF at 16'h0010, then word read 16'h0010 → busy high 3 cycles each; read completes with data_o=16'hBEEF and a single-cycle memWr_o at edge N+3.
- After the above, byte write 8'h5A at 16'h0011, then byte read 16'h0011 → 16'h005A; word read 16'h0010 → 16'h5AEF; byte read 16'h0010 → 16'h00EF.
- memEn_i held high for 10 cycles with WAIT=0 reading 16'h0010 → repeated completions every 2 cycles, each with memWr_o pulse; extra memEn_i during busy is not queued.
- Word write 16'h1234 to 16'h0020, arst_i pulsed during the second busy cycle → FSM returns to IDLE, no memWr_o; subsequent read of 16'h0020 returns the prior contents (write dropped).
- With XM_MEM_ALIGN_CHECK_EN: word write to 16'h0021 → memFault_o pulses at completion; RAM word 16'h0020 unchanged. Without the macro: the same write lands at 16'h0020.
